// File: rtl/dct_transpose_buffer.sv
// 8x8 row/column transpose between the row and column 1D DCT stages.
// Define DCT_TP_DOUBLE_BUF_EN for two-bank ping-pong; the default build uses one bank.
module dct_transpose_buffer #(
    parameter int DW = 16,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW*N-1:0] out_col,
    output logic            out_last,
    output logic [15:0]     frame_cnt
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Rows are stored packed so a write is one whole-row update.
    logic [DW*N-1:0] row_mem_r [2][N];
    logic [1:0]      full_r;
    logic            wr_bank_r;
    logic            rd_bank_r;
    logic [AW-1:0]   wr_row_r;
    logic [AW-1:0]   rd_col_r;
    logic [15:0]     frame_cnt_r;
    logic            wr_fire_s;
    logic            rd_fire_s;
    logic            wr_bank_nxt_s;
    logic            rd_bank_nxt_s;

`ifdef DCT_TP_DOUBLE_BUF_EN
    assign wr_bank_nxt_s = ~wr_bank_r;
    assign rd_bank_nxt_s = ~rd_bank_r;
`else
    assign wr_bank_nxt_s = 1'b0;
    assign rd_bank_nxt_s = 1'b0;
`endif

    assign in_ready  = ~full_r[wr_bank_r];
    assign out_valid = full_r[rd_bank_r];
    assign out_last  = out_valid & (rd_col_r == PTR_LAST);
    assign frame_cnt = frame_cnt_r;
    assign wr_fire_s = in_valid & in_ready;
    assign rd_fire_s = out_valid & out_ready;

    // Row storage: cleared on reset, written one row per accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    row_mem_r[b][r] <= '0;
                end
            end
        end else if (wr_fire_s) begin
            row_mem_r[wr_bank_r][wr_row_r] <= in_row;
        end
    end

    // Pointers, bank-full flags and drained-block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r      <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_row_r    <= '0;
            rd_col_r    <= '0;
            frame_cnt_r <= 16'd0;
        end else begin
            if (wr_fire_s) begin
                if (wr_row_r == PTR_LAST) begin
                    full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r         <= wr_bank_nxt_s;
                    wr_row_r          <= '0;
                end else begin
                    wr_row_r <= wr_row_r + PTR_ONE;
                end
            end
            // A completing read always targets the other bank than a completing write.
            if (rd_fire_s) begin
                if (rd_col_r == PTR_LAST) begin
                    full_r[rd_bank_r] <= 1'b0;
                    rd_bank_r         <= rd_bank_nxt_s;
                    rd_col_r          <= '0;
                    frame_cnt_r       <= frame_cnt_r + 16'd1;
                end else begin
                    rd_col_r <= rd_col_r + PTR_ONE;
                end
            end
        end
    end

    // Column read-out: word r of the output is row r, column rd_col of the draining bank.
    always_comb begin
        out_col = '0;
        for (int r = 0; r < N; r++) begin
            out_col[DW*r +: DW] = row_mem_r[rd_bank_r][r][DW*rd_col_r +: DW];
        end
    end

endmodule
